core_instr_prefetch: RTL and testbench
======================================

Name: core_instr_prefetch

Overview:
- Parametrised instruction-fetch front end for the RV core: replaces the single-instruction fetch adapter with a prefetch queue of DEPTH entries.
- Issues sequential reads on the instruction bus (naive_bus read semantics), buffers {pc, instr} pairs, and presents them to ID with a valid/stall handshake.
- Flushes the queue and redirects on EX/ID jumps; EX has priority over ID.
- Sits between the core pipeline IF stage and the instruction bus master port.

Parameters:
DEPTH, 4, prefetch queue entries; power of two, >= 2
BOOT_ALIGN, 2, low PC bits forced to zero (word alignment)
NOP_INSTR, 32'h0000_0013, instruction driven on o_instr when o_valid = 0

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
i_boot_addr  input  32  first fetch address, sampled during reset
i_stall  input  1  ID not accepting; head entry held
i_bus_disable  input  1  suppress new read requests
i_ex_jmp  input  1  EX redirect, highest priority
i_ex_target  input  32  EX redirect target
i_id_jmp  input  1  ID redirect
i_id_target  input  32  ID redirect target
o_valid  output  1  o_pc/o_instr hold a valid entry
o_pc  output  32  PC of the head entry
o_instr  output  32  instruction of the head entry, NOP_INSTR if invalid
rd_req  output  1  bus read request
rd_be  output  4  byte enables: 4'hF when rd_req, else 0
rd_addr  output  32  bus read address
rd_gnt  input  1  same-cycle grant
rd_data  input  32  read data, valid in the cycle after a granted request
fill_level  output  $clog2(DEPTH)+1  number of occupied queue entries, for performance counters

Behaviour:
- Reset (async, rstn = 0):
  - fpc <= {i_boot_addr[31:2], 2'b00}; queue empty; inflight = 0; drop = 0.
  - Outputs: o_valid = 0, o_instr = NOP_INSTR, o_pc = 0, rd_req = 0, fill_level = 0.
- Redirect:
  - redir = i_ex_jmp | i_id_jmp; target = i_ex_jmp ? i_ex_target : i_id_target.
  - Target is word-aligned by zeroing bits [1:0].
- Read address:
  - rd_addr = redir ? target : fpc, combinational, so the redirect costs no extra request cycle.
- Request gating:
  - rd_req = ~i_bus_disable & (count + inflight < DEPTH); redir is not a blocker.
  - On redir, count is treated as 0 and inflight as 0 for gating.
- Grant:
  - rd_req & rd_gnt → fpc <= rd_addr + 4; inflight <= 1.
  - No grant → fpc <= rd_addr, so a redirect target is retained; inflight <= 0.
- Response:
  - Cycle after a grant with inflight = 1 and drop = 0: push {pc_q, rd_data}, where pc_q is the granted address registered.
- Flush (redir = 1):
  - Queue cleared next edge.
  - A response arriving in the redir cycle is discarded.
  - drop <= 0, because a request granted in the redir cycle targets the new stream and its response is kept.
- Pop:
  - o_valid & ~i_stall & ~redir pops the head.
  - Push and pop in the same cycle are legal; count is unchanged.
- Output:
  - o_valid = ~empty & ~i_ex_jmp. An EX jump kills the head combinationally.
  - o_pc and o_instr come from the head entry, with o_instr = NOP_INSTR when o_valid = 0.
- Latency:
  - Grant at cycle N → data pushed at the N+1 edge → visible on o_* at N+2.
  - Sustained throughput is 1 instruction per cycle when rd_gnt = 1 continuously.
- Stall:
  - Head and its outputs hold stable for any number of cycles.
  - Prefetch continues until count + inflight = DEPTH; the queue never overflows.
- i_bus_disable:
  - No new request; the in-flight response is still accepted; fpc held.
- Simultaneous events:
  - ex_jmp & id_jmp → EX target wins.
  - redir & i_stall → flush still occurs.
  - redir & full → flush, new request issued.
- Wrap-around:
  - fpc + 4 wraps modulo 2^32 with no flag.
  - Queue pointers wrap modulo DEPTH.
- Reset mid-operation: all state cleared immediately; an in-flight response after reset is ignored (inflight = 0).

Decomposition:
- Package core_fetch_pkg:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - localparam NOP_INSTR default
  - function align_word()
- Sub-module core_fetch_fifo #(DEPTH, type T = fetch_entry_t):
  - synchronous FIFO with push, pop, flush, count, empty, full
  - async active-low reset
  - flush has priority over push

Test Plan:
- Reset with i_boot_addr = 32'h8000_0003, rd_gnt = 1, no stall → first rd_addr = 32'h8000_0000; o_valid rises 2 cycles after reset release; o_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles.
- Hold i_stall = 1 with DEPTH = 4, rd_gnt = 1 → fill_level saturates at 4; rd_req drops; o_pc/o_instr stay constant; release → 4 entries drain on consecutive cycles, then streaming resumes.
- i_ex_jmp = 1 with target 0x0000_1000 while queue holds 3 entries and a response is in flight → same-cycle rd_addr = 0x1000; o_valid = 0 that cycle; old response dropped; next o_pc = 0x1000 two cycles later.
- i_ex_jmp and i_id_jmp asserted together, targets 0x200 and 0x300 → rd_addr = 0x200; no entry with pc 0x300 ever appears.
- rd_gnt alternating 0/1 starting at 0x100 → each address requested until granted; no duplicates or gaps in the o_pc stream (0x100, 0x104, ...).
- Assert rstn = 0 mid-stream with the queue non-empty → o_valid = 0 and rd_req = 0 immediately (asynchronous); after release, fetch restarts at i_boot_addr.

Source files
------------

// File: rtl/core_fetch_pkg.sv
`default_nettype none
// ============================================================================
// core_fetch_pkg : shared types and helpers for the instruction prefetch front end
// Rev 1.0
// ============================================================================
package core_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr,
                                             input int unsigned nbits = 2);
    return addr & ~((32'h1 << nbits) - 32'h1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_fetch_fifo.sv
`default_nettype none
// ============================================================================
// core_fetch_fifo : synchronous FIFO with flush; flush overrides push and pop
// Rev 1.0
// ============================================================================
module core_fetch_fifo
  import core_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output T                       data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned     AW       = $clog2(DEPTH);
  localparam logic [AW:0]     CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]     CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]   PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  T              mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign do_pop  = pop_i & ~empty_o;
  // A full queue can still accept when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/core_instr_prefetch.sv
`default_nettype none
// ============================================================================
// core_instr_prefetch : sequential instruction prefetch queue with redirect
// Rev 1.0
// ============================================================================
module core_instr_prefetch
  import core_fetch_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned BOOT_ALIGN = 2,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [31:0]            i_boot_addr,
  input  logic                   i_stall,
  input  logic                   i_bus_disable,
  input  logic                   i_ex_jmp,
  input  logic [31:0]            i_ex_target,
  input  logic                   i_id_jmp,
  input  logic [31:0]            i_id_target,
  output logic                   o_valid,
  output logic [31:0]            o_pc,
  output logic [31:0]            o_instr,
  output logic                   rd_req,
  output logic [3:0]             rd_be,
  output logic [31:0]            rd_addr,
  input  logic                   rd_gnt,
  input  logic [31:0]            rd_data,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic          booted_q;
  logic [31:0]   target;
  logic [31:0]   base_pc;
  logic          redir;
  logic          grant;
  logic          push;
  logic          pop;
  logic          empty;
  logic          unused_full;
  logic [CW-1:0] count;
  logic [CW-1:0] occ;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign redir  = i_ex_jmp | i_id_jmp;
  assign target = align_word(i_ex_jmp ? i_ex_target : i_id_target);

  // Until the first edge after reset the fetch PC is the boot address itself.
  assign base_pc = booted_q ? fpc_q : align_word(i_boot_addr, BOOT_ALIGN);
  assign rd_addr = redir ? target : base_pc;

  assign occ    = redir ? '0 : count + {{(CW-1){1'b0}}, inflight_q};
  assign rd_req = rstn & ~i_bus_disable & (occ < DEPTH_C);
  assign rd_be  = {4{rd_req}};
  assign grant  = rd_req & rd_gnt;

  always_comb begin
    fpc_d      = rd_addr;
    pc_d       = pc_q;
    inflight_d = 1'b0;
    if (grant) begin
      fpc_d      = rd_addr + 32'd4;
      pc_d       = rd_addr;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fpc_q      <= '0;
      pc_q       <= '0;
      inflight_q <= 1'b0;
      booted_q   <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      booted_q   <= 1'b1;
    end
  end

  // Responses landing in a redirect cycle belong to the old stream.
  assign push       = inflight_q & ~redir;
  assign push_entry = '{pc: pc_q, instr: rd_data};
  assign pop        = o_valid & ~i_stall & ~redir;

  core_fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (redir),
    .data_o  (head),
    .count_o (count),
    .empty_o (empty),
    .full_o  (unused_full)
  );

  assign o_valid    = ~empty & ~i_ex_jmp;
  assign o_pc       = o_valid ? head.pc : '0;
  assign o_instr    = o_valid ? head.instr : NOP_INSTR;
  assign fill_level = count;

endmodule
`default_nettype wire

// File: tb/tb_core_instr_prefetch.sv
`default_nettype none
// ============================================================================
// tb_core_instr_prefetch : randomized bench with queue-level reference model
// Rev 1.0
// ============================================================================
module tb_core_instr_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] i_boot_addr;
  logic        i_stall, i_bus_disable, i_ex_jmp, i_id_jmp;
  logic [31:0] i_ex_target, i_id_target;
  logic        o_valid;
  logic [31:0] o_pc, o_instr;
  logic        rd_req;
  logic [3:0]  rd_be;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic [31:0] rd_data;
  logic [$clog2(DEPTH):0] fill_level;

  always #5 clk = ~clk;

  core_instr_prefetch #(
    .DEPTH      (DEPTH),
    .BOOT_ALIGN (2),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_boot_addr   (i_boot_addr),
    .i_stall       (i_stall),
    .i_bus_disable (i_bus_disable),
    .i_ex_jmp      (i_ex_jmp),
    .i_ex_target   (i_ex_target),
    .i_id_jmp      (i_id_jmp),
    .i_id_target   (i_id_target),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .rd_req        (rd_req),
    .rd_be         (rd_be),
    .rd_addr       (rd_addr),
    .rd_gnt        (rd_gnt),
    .rd_data       (rd_data),
    .fill_level    (fill_level)
  );

  // Instruction memory contents are a fixed function of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F0F;
  endfunction

  logic [31:0] bus_addr = 32'h0;
  always @(posedge clk) if (rstn && rd_req && rd_gnt) bus_addr <= rd_addr;
  assign rd_data = memf(bus_addr);

  int tests = 0;
  int fails = 0;

  // Reference model: buffered PCs, one outstanding request, next sequential PC.
  logic [31:0] mq[$];
  bit          pend_v;
  logic [31:0] pend_a;
  logic [31:0] m_fpc;
  logic [31:0] stream_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input logic [31:0] boot);
    mq.delete();
    pend_v    = 0;
    m_fpc     = {boot[31:2], 2'b00};
    stream_pc = m_fpc;
  endtask

  task automatic check_step();
    bit          redir, mv, mreq;
    logic [31:0] tgt, raddr;
    int          occ;
    redir = i_ex_jmp | i_id_jmp;
    tgt   = i_ex_jmp ? i_ex_target : i_id_target;
    tgt[1:0] = 2'b00;
    mv    = (mq.size() != 0) && !i_ex_jmp;
    raddr = redir ? tgt : m_fpc;
    occ   = redir ? 0 : mq.size() + int'(pend_v);
    mreq  = !i_bus_disable && (occ < DEPTH);

    chk("o_valid", o_valid, mv);
    if (mv) begin
      chk("o_pc", o_pc, mq[0]);
      chk("o_instr", o_instr, memf(mq[0]));
    end else begin
      chk("o_instr_nop", o_instr, NOP);
    end
    chk("rd_req", rd_req, mreq);
    chk("rd_be", rd_be, mreq ? 4'hF : 4'h0);
    chk("rd_addr", rd_addr, raddr);
    chk("fill_level", fill_level, mq.size());
    if (mv && !i_stall && !redir) begin
      chk("stream_pc", o_pc, stream_pc);
      stream_pc = stream_pc + 32'd4;
    end

    if (redir) begin
      mq.delete();
      stream_pc = tgt;
    end else begin
      if (mv && !i_stall) void'(mq.pop_front());
      if (pend_v) mq.push_back(pend_a);
    end
    if (mreq && rd_gnt) begin
      pend_v = 1;
      pend_a = raddr;
      m_fpc  = raddr + 32'd4;
    end else begin
      pend_v = 0;
      m_fpc  = raddr;
    end
  endtask

  task automatic cyc(input bit st, input bit gn, input bit dis,
                     input bit ex, input logic [31:0] ext,
                     input bit id, input logic [31:0] idt);
    @(posedge clk);
    #1;
    i_stall = st; rd_gnt = gn; i_bus_disable = dis;
    i_ex_jmp = ex; i_ex_target = ext; i_id_jmp = id; i_id_target = idt;
    @(negedge clk);
    check_step();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    i_stall = 0; rd_gnt = 1; i_bus_disable = 0;
    i_ex_jmp = 0; i_id_jmp = 0; i_ex_target = 0; i_id_target = 0;
    model_reset(i_boot_addr);
    @(negedge clk);
    check_step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held;
    rstn = 1'b0;
    i_boot_addr = 32'h8000_0003;
    i_stall = 0; i_bus_disable = 0; rd_gnt = 1;
    i_ex_jmp = 0; i_ex_target = 0; i_id_jmp = 0; i_id_target = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_req", rd_req, 1'b0);
    chk("rst_fill", fill_level, 0);
    chk("rst_instr", o_instr, NOP);
    chk("rst_pc", o_pc, 32'h0);

    // Boot streaming
    release_reset();
    chk("boot_addr", rd_addr, 32'h8000_0000);
    chk("boot_v0", o_valid, 1'b0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("boot_v1", o_valid, 1'b0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("boot_v2", o_valid, 1'b1);
    chk("boot_pc0", o_pc, 32'h8000_0000);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("boot_pc1", o_pc, 32'h8000_0004);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("boot_pc2", o_pc, 32'h8000_0008);

    // EX jump with three entries buffered and a response in flight
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 32'h0000_1002, 0, 0);
    chk("ex_fill3", fill_level, 3);
    chk("ex_addr", rd_addr, 32'h0000_1000);
    chk("ex_kill", o_valid, 1'b0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("ex_gap", o_valid, 1'b0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("ex_pc", o_pc, 32'h0000_1000);

    // Stall until the queue saturates, then drain
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);
    held = 32'h0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0, 0, 0, 0, 0);
      if (i == 0) held = o_pc;
      else chk("stall_hold", o_pc, held);
      if (i >= 4) begin
        chk("stall_full", fill_level, DEPTH);
        chk("stall_noreq", rd_req, 1'b0);
      end
    end
    repeat (8) cyc(0, 1, 0, 0, 0, 0, 0);

    // Simultaneous EX and ID jump
    cyc(0, 1, 0, 1, 32'h0000_0200, 1, 32'h0000_0300);
    chk("both_addr", rd_addr, 32'h0000_0200);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("no_id_pc", (o_valid && o_pc == 32'h0000_0300), 1'b0);
    end

    // Alternating grant from 0x100
    cyc(0, 0, 0, 0, 0, 1, 32'h0000_0100);
    chk("alt_addr0", rd_addr, 32'h0000_0100);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("alt_retain", rd_addr, 32'h0000_0100);
    for (int i = 0; i < 16; i++) cyc(0, i[0], 0, 0, 0, 0, 0);

    // Randomized traffic including wrap-around targets
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t1, t2;
      t1 = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      t2 = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70,
          $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 3, t1,
          $urandom_range(0, 99) < 3, t2);
    end

    // Asynchronous reset with a non-empty queue
    repeat (4) cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, 1, 0, 0, 0, 0, 0);
    chk("pre_rst_nonempty", (fill_level != 0), 1'b1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    i_boot_addr = 32'h0000_0F07;
    #1;
    chk("arst_valid", o_valid, 1'b0);
    chk("arst_req", rd_req, 1'b0);
    chk("arst_fill", fill_level, 0);
    chk("arst_instr", o_instr, NOP);
    repeat (2) @(posedge clk);
    release_reset();
    chk("reboot_addr", rd_addr, 32'h0000_0F04);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("reboot_pc", o_pc, 32'h0000_0F04);
    repeat (6) cyc(0, 1, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
